// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - direct-mapped branch target buffer with 2-bit counters
//
// Purpose:
//   Fetch-stage next-PC predictor. Lookup is purely combinational (zero latency).
//   Resolution updates from EX/ID are written at the rising clock edge.
//   Each entry holds a valid bit, a tag, a target and a 2-bit saturating
//   direction counter. The taken target is used only when the counter is
//   2 or more; otherwise the fall-through PC+1 is predicted.
//
// Parameters:
//   WORD_SIZE      PC / datapath width in bits
//   IDX_BITS       index width; the table has 2^IDX_BITS entries
//
// Ports:
//   Clk            single clock, rising edge
//   Reset          synchronous, active-high
//   PC             fetch PC being looked up
//   Prediction     predicted next PC
//   PredHit        PC matches a valid entry
//   UpdValid       resolution update request this cycle
//   UpdPC          PC of the resolved branch/jump
//   UpdTaken       resolved direction (1 = taken)
//   UpdTarget      resolved taken target
//   UpdIsJump      resolved instruction is an unconditional jump
//   UpdMispredict  pipeline flagged this resolution as mispredicted
//   NumLookups     count of non-reset cycles (one lookup per cycle)
//   NumMispredicts count of updates flagged as mispredicted

module btb_predictor #(
    parameter int WORD_SIZE = 16,
    parameter int IDX_BITS  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] PC,
    output logic [WORD_SIZE-1:0] Prediction,
    output logic                 PredHit,
    input  logic                 UpdValid,
    input  logic [WORD_SIZE-1:0] UpdPC,
    input  logic                 UpdTaken,
    input  logic [WORD_SIZE-1:0] UpdTarget,
    input  logic                 UpdIsJump,
    input  logic                 UpdMispredict,
    output logic [WORD_SIZE-1:0] NumLookups,
    output logic [WORD_SIZE-1:0] NumMispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = WORD_SIZE - IDX_BITS;

    localparam logic [1:0] CTR_WEAK_TAKEN   = 2'd2;
    localparam logic [1:0] CTR_STRONG_TAKEN = 2'd3;

    // ------------------------------------------------------------------
    // Storage. Valid bits and counters are reset; tags and targets are
    // only meaningful behind a valid bit, so they carry no reset.
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] r_target [ENTRIES];

    logic [WORD_SIZE-1:0] r_num_lookups;
    logic [WORD_SIZE-1:0] r_num_mispredicts;

    // ------------------------------------------------------------------
    // Lookup path (combinational, reads pre-update state)
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0]  w_lk_idx;
    logic [TAG_W-1:0]     w_lk_tag;
    logic                 w_lk_hit;
    logic [1:0]           w_lk_ctr;
    logic [WORD_SIZE-1:0] w_lk_target;
    logic [WORD_SIZE-1:0] w_pc_plus1;

    assign w_lk_idx    = PC[IDX_BITS-1:0];
    assign w_lk_tag    = PC[WORD_SIZE-1:IDX_BITS];
    assign w_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_lk_ctr    = r_ctr[w_lk_idx];
    assign w_lk_target = r_target[w_lk_idx];
    // Natural WORD_SIZE wrap: all-ones + 1 becomes zero.
    assign w_pc_plus1  = PC + {{(WORD_SIZE-1){1'b0}}, 1'b1};

    assign PredHit    = w_lk_hit;
    // Counter MSB set means counter >= 2, i.e. predict taken.
    assign Prediction = (w_lk_hit && w_lk_ctr[1]) ? w_lk_target : w_pc_plus1;

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] w_upd_idx;
    logic [TAG_W-1:0]    w_upd_tag;
    logic                w_upd_hit;
    logic [1:0]          w_upd_ctr;
    logic [1:0]          w_ctr_next;
    logic                w_upd_en;
    logic                w_alloc;
    logic                w_wr_target;

    assign w_upd_idx = UpdPC[IDX_BITS-1:0];
    assign w_upd_tag = UpdPC[WORD_SIZE-1:IDX_BITS];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_ctr = r_ctr[w_upd_idx];

    // Updates in a reset cycle are dropped entirely.
    assign w_upd_en    = UpdValid && !Reset;
    // Only a taken miss allocates; a not-taken miss leaves the entry alone.
    assign w_alloc     = w_upd_en && !w_upd_hit && UpdTaken;
    // Target is rewritten on any taken resolution (hit refresh or allocation).
    assign w_wr_target = w_upd_en && UpdTaken;

    // Counter transition for an update that hits.
    always_comb begin
        w_ctr_next = w_upd_ctr;
        if (UpdIsJump) begin
            w_ctr_next = CTR_STRONG_TAKEN;
        end else if (UpdTaken) begin
            if (w_upd_ctr != 2'd3) begin
                w_ctr_next = w_upd_ctr + 2'd1;
            end
        end else begin
            if (w_upd_ctr != 2'd0) begin
                w_ctr_next = w_upd_ctr - 2'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'd0;
            end
        end else if (UpdValid) begin
            if (w_upd_hit) begin
                r_ctr[w_upd_idx] <= w_ctr_next;
            end else if (UpdTaken) begin
                // Allocation evicts whatever occupied this index.
                r_valid[w_upd_idx] <= 1'b1;
                r_ctr[w_upd_idx]   <= UpdIsJump ? CTR_STRONG_TAKEN : CTR_WEAK_TAKEN;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_alloc) begin
            r_tag[w_upd_idx] <= w_upd_tag;
        end
        if (w_wr_target) begin
            r_target[w_upd_idx] <= UpdTarget;
        end
    end

    // ------------------------------------------------------------------
    // Statistics counters (free-running, wrap at WORD_SIZE)
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_num_lookups     <= '0;
            r_num_mispredicts <= '0;
        end else begin
            r_num_lookups <= r_num_lookups + {{(WORD_SIZE-1){1'b0}}, 1'b1};
            if (UpdValid && UpdMispredict) begin
                r_num_mispredicts <= r_num_mispredicts + {{(WORD_SIZE-1){1'b0}}, 1'b1};
            end
        end
    end

    assign NumLookups     = r_num_lookups;
    assign NumMispredicts = r_num_mispredicts;

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - scoreboard bench for btb_predictor

module tb_btb_predictor;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] PC;
    logic [15:0] Prediction;
    logic        PredHit;
    logic        UpdValid;
    logic [15:0] UpdPC;
    logic        UpdTaken;
    logic [15:0] UpdTarget;
    logic        UpdIsJump;
    logic        UpdMispredict;
    logic [15:0] NumLookups;
    logic [15:0] NumMispredicts;

    btb_predictor #(.WORD_SIZE(16), .IDX_BITS(4)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .PC             (PC),
        .Prediction     (Prediction),
        .PredHit        (PredHit),
        .UpdValid       (UpdValid),
        .UpdPC          (UpdPC),
        .UpdTaken       (UpdTaken),
        .UpdTarget      (UpdTarget),
        .UpdIsJump      (UpdIsJump),
        .UpdMispredict  (UpdMispredict),
        .NumLookups     (NumLookups),
        .NumMispredicts (NumMispredicts)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic        hit;
        logic [15:0] pred;
        logic [15:0] nl;
        logic [15:0] nm;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference table
    bit        m_valid [16];
    bit [11:0] m_tag   [16];
    bit [15:0] m_tgt   [16];
    int        m_ctr   [16];
    bit [15:0] m_nl;
    bit [15:0] m_nm;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 0;
        end
        m_nl = 16'h0;
        m_nm = 16'h0;
    endtask

    // One clock cycle: drive, predict from the reference, compare, then advance
    // the reference at the clock edge.
    task automatic step(input string tag, input bit rst, input bit [15:0] pc,
                        input bit uv, input bit [15:0] upc, input bit ut,
                        input bit [15:0] utg, input bit uj, input bit um);
        exp_t e;
        int   li;
        int   ui;
        bit   uhit;
        @(negedge Clk);
        Reset = rst; PC = pc; UpdValid = uv; UpdPC = upc; UpdTaken = ut;
        UpdTarget = utg; UpdIsJump = uj; UpdMispredict = um;

        li    = int'(pc[3:0]);
        e.tag = tag;
        e.hit = m_valid[li] && (m_tag[li] == pc[15:4]);
        e.pred = (e.hit && m_ctr[li] >= 2) ? m_tgt[li] : pc + 16'd1;
        e.nl  = m_nl;
        e.nm  = m_nm;
        exp_q.push_back(e);

        #1;
        e = exp_q.pop_front();
        check_val({e.tag, ".hit"},  {31'd0, PredHit}, {31'd0, e.hit});
        check_val({e.tag, ".pred"}, {16'd0, Prediction}, {16'd0, e.pred});
        check_val({e.tag, ".nl"},   {16'd0, NumLookups}, {16'd0, e.nl});
        check_val({e.tag, ".nm"},   {16'd0, NumMispredicts}, {16'd0, e.nm});

        @(posedge Clk);
        if (rst) begin
            model_clear();
        end else begin
            m_nl = m_nl + 16'd1;
            if (uv && um) m_nm = m_nm + 16'd1;
            if (uv) begin
                ui   = int'(upc[3:0]);
                uhit = m_valid[ui] && (m_tag[ui] == upc[15:4]);
                if (uhit) begin
                    if (uj)      m_ctr[ui] = 3;
                    else if (ut) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                    else         m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                    if (ut) m_tgt[ui] = utg;
                end else if (ut) begin
                    m_valid[ui] = 1'b1;
                    m_tag[ui]   = upc[15:4];
                    m_tgt[ui]   = utg;
                    m_ctr[ui]   = uj ? 3 : 2;
                end
            end
        end
    endtask

    task automatic look(input string tag, input bit [15:0] pc);
        step(tag, 1'b0, pc, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; PC = 16'h0; UpdValid = 1'b0; UpdPC = 16'h0; UpdTaken = 1'b0;
        UpdTarget = 16'h0; UpdIsJump = 1'b0; UpdMispredict = 1'b0;
        model_clear();
        repeat (2) @(posedge Clk);

        // Reset cycle with a concurrent allocating update: must be dropped.
        step("rst_upd", 1'b1, 16'h0020, 1'b1, 16'h0005, 1'b1, 16'h0055, 1'b0, 1'b1);
        look("post_rst", 16'h0020);
        check_val("post_rst.nl_zero", {16'd0, m_nl}, 32'd1);
        look("rst_drop", 16'h0005);

        // Allocate 0x0020 -> 0x0040, weak taken.
        step("alloc20", 1'b0, 16'h1234, 1'b1, 16'h0020, 1'b1, 16'h0040, 1'b0, 1'b0);
        look("hit20", 16'h0020);
        check_val("hit20.direct", {16'd0, Prediction}, 32'h0040);

        // Not-taken updates saturate at 0; a later taken moves to 1 only.
        step("nt1", 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 1'b1);
        step("nt2", 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("nt3", 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b0, 16'h0000, 1'b0, 1'b0);
        look("ctr0", 16'h0020);
        check_val("ctr0.direct", {16'd0, Prediction}, 32'h0021);
        step("tk_after0", 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b1, 16'h0040, 1'b0, 1'b0);
        look("ctr1", 16'h0020);

        // Not-taken miss must not allocate.
        step("nt_miss", 1'b0, 16'h0000, 1'b1, 16'h0107, 1'b0, 16'h0333, 1'b0, 1'b0);
        look("nt_miss_chk", 16'h0107);

        // Aliasing on index 0.
        step("alias30", 1'b0, 16'h0000, 1'b1, 16'h0030, 1'b1, 16'h0077, 1'b0, 1'b0);
        look("alias20", 16'h0020);
        look("alias30hit", 16'h0030);
        check_val("alias30.direct", {31'd0, PredHit}, 32'd1);

        // Same-cycle lookup and jump allocation on 0x0005.
        step("same5", 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0099, 1'b1, 1'b0);
        look("next5", 16'h0005);
        step("j_dec1", 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("j_dec2", 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0);
        look("j_ctr1", 16'h0005);
        // Jump hit forces counter 3 from 1 and refreshes target.
        step("j_force", 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b1, 16'h00AA, 1'b1, 1'b0);
        step("j_dec3", 1'b0, 16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0);
        look("j_ctr2", 16'h0005);

        // PC wrap on the fall-through path.
        look("wrap", 16'hFFFF);

        // Random traffic over a small PC set to exercise collisions.
        for (int i = 0; i < 300; i++) begin
            step("rnd", 1'b0, {12'h00 + 12'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                 1'($urandom_range(0, 1)),
                 {12'h00 + 12'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        // Drive the mispredict counter up to wrap; lookup counter wraps too.
        while (m_nm != 16'hFFFF) begin
            step("misp_fill", 1'b0, 16'h0800, 1'b1, 16'h0F0E, 1'b0, 16'h0000, 1'b0, 1'b1);
        end
        step("misp_last", 1'b0, 16'h0800, 1'b1, 16'h0F0E, 1'b0, 16'h0000, 1'b0, 1'b1);
        look("misp_wrap", 16'h0800);
        check_val("misp_wrap.direct", {16'd0, NumMispredicts}, 32'd0);

        // Mid-operation reset overrides a concurrent allocation.
        step("rst_mid", 1'b1, 16'h0009, 1'b1, 16'h0009, 1'b1, 16'h0123, 1'b1, 1'b1);
        look("rst_mid9", 16'h0009);
        look("rst_mid20", 16'h0020);
        check_val("rst_mid.direct", {31'd0, PredHit}, 32'd0);

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, datapath and PC width in bits.
REQ-002 SHALL have parameter IDX_BITS, default 4, BTB index width; entries = 2^IDX_BITS.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port PC, input, WORD_SIZE, fetch-stage PC being looked up.
REQ-006 SHALL have port Prediction, output, WORD_SIZE, predicted next PC for the IF stage.
REQ-007 SHALL have port PredHit, output, 1, high when PC hits a valid BTB entry.
REQ-008 SHALL have port UpdValid, input, 1, high to request a resolution update from the EX/ID stage this cycle.
REQ-009 SHALL have port UpdPC, input, WORD_SIZE, PC of the resolved branch or jump.
REQ-010 SHALL have port UpdTaken, input, 1, actual direction (1 = taken).
REQ-011 SHALL have port UpdTarget, input, WORD_SIZE, actual taken target.
REQ-012 SHALL have port UpdIsJump, input, 1, resolved instruction is an unconditional jump.
REQ-013 SHALL have port UpdMispredict, input, 1, pipeline flagged this resolution as a misprediction.
REQ-014 SHALL have port NumLookups, output, WORD_SIZE, count of cycles with a lookup performed.
REQ-015 SHALL have port NumMispredicts, output, WORD_SIZE, count of updates with UpdMispredict high.

Function
REQ-016 Entry SHALL hold: valid (1), tag = PC[WORD_SIZE-1:IDX_BITS], target (WORD_SIZE), 2-bit saturating counter.
REQ-017 Index SHALL be PC[IDX_BITS-1:0]; direct-mapped, no associativity.
REQ-018 Lookup SHALL be combinational, zero latency: PredHit = valid && tag match.
REQ-019 Prediction SHALL be entry target when PredHit and counter >= 2, else PC+1 (WORD_SIZE wrap: 16'hFFFF+1 = 0).
REQ-020 Update SHALL occur at the rising edge where UpdValid=1 and Reset=0; visible to lookups from the next cycle.
REQ-021 Same-cycle lookup and update to the same index SHALL return pre-update state.
REQ-022 Update miss with UpdTaken=1 SHALL allocate: valid=1, tag, target=UpdTarget, counter=2 (UpdIsJump=1: counter=3); evicts any previous occupant.
REQ-023 Update miss with UpdTaken=0 SHALL not allocate or modify the entry.
REQ-024 Update hit, UpdTaken=1: counter = min(counter+1,3), target = UpdTarget.
REQ-025 Update hit, UpdTaken=0: counter = max(counter-1,0); target and valid unchanged.
REQ-026 Update hit with UpdIsJump=1 SHALL force counter=3 regardless of prior value.
REQ-027 NumLookups SHALL increment by 1 every non-reset cycle; wraps FFFF -> 0.
REQ-028 NumMispredicts SHALL increment when UpdValid && UpdMispredict in a non-reset cycle; wraps FFFF -> 0.
REQ-029 X on PC with no valid entries SHALL still yield PredHit=0 only if valid bits are known; valid bits SHALL never be X after reset.

Reset
REQ-030 Reset=1 at a rising edge SHALL clear all valid bits, counters to 0, NumLookups and NumMispredicts to 0; targets/tags need not be cleared.
REQ-031 Update asserted in a reset cycle SHALL be discarded.
REQ-032 During and after reset, outputs SHALL be PredHit=0, Prediction=PC+1 until the first allocation.
REQ-033 Reset mid-operation SHALL take effect at that edge, overriding any concurrent update or counter increment.

Verification
REQ-034 Reset, PC=16'h0020 -> PredHit=0, Prediction=16'h0021; NumLookups=0 the cycle after reset deasserts.
REQ-035 Update PC=16'h0020, Taken=1, Target=16'h0040; next cycle PC=16'h0020 -> PredHit=1, Prediction=16'h0040 (counter 2).
REQ-036 Two not-taken updates on PC=16'h0020 -> counter 0, Prediction=16'h0021, PredHit=1; third not-taken holds at 0.
REQ-037 Aliasing: allocate 16'h0020, then taken update 16'h0030 (same index 0) -> 16'h0020 lookup PredHit=0; 16'h0030 hits.
REQ-038 Same-cycle lookup and allocating update on 16'h0005 -> PredHit=0 that cycle, 1 next cycle; jump update gives counter 3.
REQ-039 Preload NumMispredicts to FFFF via updates, one more mispredict update -> 0; Reset during update -> entry not allocated.
